spi_frame_rx: RTL
=================

Name: spi_frame_rx

Overview:
SPI slave receive front-end in the ok_spi path, directly upstream of the 64-bit shift-in register. Brings asynchronous sck/cs_n/mosi into the CLK domain and detects sample edges. Drives that register's d_in, en and rst inputs, one en pulse per received bit. Counts bits per chip-select window, signals frame completion, and flags short and overrun frames.

Parameters:
FRAME_BITS, 64, bits per frame; must match the downstream shift register width.
SYNC_STAGES, 2, synchronizer flops per input; minimum 2.
SAMPLE_RISING, 1, 1 = sample mosi on sck rising edge; 0 = falling edge.

Ports:
CLK  in  1  system clock; all logic on posedge CLK.
rst_n  in  1  asynchronous, active-low reset.
sck  in  1  SPI clock, asynchronous to CLK.
cs_n  in  1  SPI chip select, active low, asynchronous.
mosi  in  1  SPI data in, asynchronous.
bit_out  out  1  data bit to shift register d_in.
bit_en  out  1  one-cycle shift enable to shift register en.
shift_clr  out  1  one-cycle clear to shift register rst.
frame_done  out  1  one-cycle pulse; shift register holds a complete frame.
short_frame  out  1  one-cycle pulse; cs_n deasserted mid-frame.
overrun  out  1  sticky; sck edges after a completed frame in the same cs window.
bit_count  out  $clog2(FRAME_BITS+1)  bits received in the current window.
frame_count  out  16  completed frames since reset; wraps 0xFFFF->0.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: all outputs 0. Synchronized sck resets to the idle level (SAMPLE_RISING ? 0 : 1). Synchronized cs_n resets to 1, synchronized mosi to 0. State resets to IDLE.
- sck, cs_n and mosi each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one further registered copy.
- Sample edge: synchronized sck 0->1 when SAMPLE_RISING=1, 1->0 otherwise.
- Latency: a pin transition to the corresponding bit_en/shift_clr output is SYNC_STAGES+1 CLK cycles.
- Requirement: CLK at least 4x sck frequency. No error detection for violations.
- States: IDLE, RECV, DONE. All outputs are registered.
- Any state, cs_n fall: shift_clr=1 for one cycle; bit_count<=0; overrun<=0; go to RECV.
- IDLE: sample edges ignored; bit_en stays 0.
- RECV, sample edge:
  - bit_en=1 for one cycle and bit_out = synchronized mosi captured at that edge.
  - bit_count increments.
  - On the edge that makes bit_count==FRAME_BITS, go to DONE.
  - frame_done=1 in the cycle after that final bit_en, so downstream contents are already updated.
  - frame_count increments together with frame_done.
- RECV, cs_n rise:
  - 0 < bit_count < FRAME_BITS: short_frame=1 for one cycle; go to IDLE.
  - bit_count==0: no flag; go to IDLE.
- DONE:
  - Sample edge: overrun<=1; bit_en stays 0; bit_count saturates at FRAME_BITS.
  - cs_n rise: go to IDLE with no flags.
- Simultaneous events in one cycle:
  - cs_n rise and sample edge: the edge is ignored and cs_n handling applies (no bit_en, no count).
  - cs_n fall and sample edge: clear takes priority; the edge is ignored.
- Reset mid-frame: immediately returns to reset values; the partial frame is discarded with no flags.
- bit_count holds its value after the window closes until the next cs_n fall.

Optional Feature:
Macro SPI_RX_GLITCH_FILTER_EN.
- Defined: the synchronized sck must hold a new level for 2 consecutive CLK samples before the internal filtered sck changes. Single-cycle sck glitches produce no edge. Pin-to-bit_en latency becomes SYNC_STAGES+2. cs_n and mosi are unfiltered, but mosi gets one extra delay flop to stay aligned with filtered sck.
- Undefined: no filter; latency is SYNC_STAGES+1.

Decomposition:
- Package spi_rx_pkg holds:
  - state enum rx_state_t {IDLE, RECV, DONE};
  - localparam FRAME_CNT_W=16;
  - a function computing bit_count width from FRAME_BITS.
- One sub-module is natural: sync_edge_det (SYNC_STAGES synchronizer + rise/fall pulse outputs, reset-value parameter). Instantiate it for sck and cs_n; mosi uses a plain synchronizer chain.

Test Plan:
- Frame, SAMPLE_RISING=1, CLK 8x sck:
  - Stimulus: cs_n low, 64 bits of 0xDEADBEEF_01234567 MSB first, cs_n high.
  - Response: exactly 64 bit_en pulses whose bit_out sequence equals the word; one shift_clr; frame_done once, 1 cycle after the last bit_en; frame_count=1; no short_frame or overrun.
- Short frame: 10 bits, then cs_n high -> short_frame pulses once; bit_count=10; frame_count unchanged; IDLE.
- Overrun: 66 edges in one cs window -> 64 bit_en; frame_done once; overrun=1 from the 65th edge; overrun cleared by the next cs_n fall.
- Back-to-back: two 64-bit frames with cs_n high for 4 CLK between them -> two frame_done pulses and frame_count=2. A shift_clr precedes each frame's first bit_en.
- Async reset: assert rst_n low after 30 bits, release, then send a full frame -> outputs are 0 during reset; no flags; the next frame completes normally; frame_count=1.
- Glitch filter (SPI_RX_GLITCH_FILTER_EN defined): a 1-CLK sck pulse mid-frame adds no bit_en, and latency measures SYNC_STAGES+2. Without the macro, the same pulse adds one bit_en.

Source files
------------

// File: rtl/spi_frame_rx_pkg.sv
// Shared types and sizing helpers for the SPI slave receive front-end.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } rx_state_t;

    localparam int FRAME_CNT_W = 16;

    function automatic int cnt_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/spi_frame_rx_sync_edge_det.sv
// Multi-flop synchronizer with registered-reference edge detection and an
// optional two-sample level filter in front of the edge detector.
module sync_edge_det #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0,
    parameter bit FILTER  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              ref_q;
    logic              sync_last;
    logic              lvl;

    assign sync_last = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    generate
        if (FILTER) begin : g_filt
            logic hold_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= RST_VAL;
                end else begin
                    hold_q <= sync_last;
                end
            end

            // Accept a new level only once two consecutive samples agree.
            assign lvl = (sync_last == hold_q) ? sync_last : ref_q;
        end else begin : g_nofilt
            assign lvl = sync_last;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= RST_VAL;
        end else begin
            ref_q <= lvl;
        end
    end

    assign rise_o = lvl & ~ref_q;
    assign fall_o = ~lvl & ref_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave receive front-end feeding a FRAME_BITS-wide shift-in register.
// Define SPI_RX_GLITCH_FILTER_EN to add a two-sample glitch filter on sck.
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int FRAME_BITS    = 64,
    parameter int SYNC_STAGES   = 2,
    parameter bit SAMPLE_RISING = 1'b1
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic                            sck,
    input  logic                            cs_n,
    input  logic                            mosi,
    output logic                            bit_out,
    output logic                            bit_en,
    output logic                            shift_clr,
    output logic                            frame_done,
    output logic                            short_frame,
    output logic                            overrun,
    output logic [$clog2(FRAME_BITS+1)-1:0] bit_count,
    output logic [FRAME_CNT_W-1:0]          frame_count
);

    localparam int CW = cnt_width(FRAME_BITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

`ifdef SPI_RX_GLITCH_FILTER_EN
    localparam bit SCK_FILTER  = 1'b1;
    localparam int MOSI_STAGES = SYNC_STAGES + 1;
`else
    localparam bit SCK_FILTER  = 1'b0;
    localparam int MOSI_STAGES = SYNC_STAGES;
`endif

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sample_edge;
    logic mosi_s;
    logic [MOSI_STAGES-1:0] mosi_q;

    rx_state_t            state_q, state_d;
    logic                 bit_out_q, bit_out_d;
    logic                 bit_en_q, bit_en_d;
    logic                 clr_q, clr_d;
    logic                 done_q, done_d;
    logic                 pend_q, pend_d;
    logic                 short_q, short_d;
    logic                 ovr_q, ovr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    sync_edge_det #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(!SAMPLE_RISING),
        .FILTER (SCK_FILTER)
    ) u_sck_sync (
        .clk   (CLK),
        .rst_n (rst_n),
        .d_i   (sck),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    sync_edge_det #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1),
        .FILTER (1'b0)
    ) u_cs_sync (
        .clk   (CLK),
        .rst_n (rst_n),
        .d_i   (cs_n),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    // mosi depth tracks the sck path so the captured bit lines up with its edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[MOSI_STAGES-2:0], mosi};
        end
    end

    assign mosi_s      = mosi_q[MOSI_STAGES-1];
    assign sample_edge = SAMPLE_RISING ? sck_rise : sck_fall;

    always_comb begin
        state_d   = state_q;
        bit_out_d = bit_out_q;
        bit_en_d  = 1'b0;
        clr_d     = 1'b0;
        pend_d    = 1'b0;
        short_d   = 1'b0;
        ovr_d     = ovr_q;
        cnt_d     = cnt_q;
        done_d    = pend_q;
        fcnt_d    = pend_q ? fcnt_q + FRAME_CNT_W'(1) : fcnt_q;

        if (cs_fall) begin
            clr_d   = 1'b1;
            cnt_d   = '0;
            ovr_d   = 1'b0;
            state_d = RECV;
        end else begin
            unique case (state_q)
                IDLE: ;
                RECV: begin
                    if (cs_rise) begin
                        short_d = (cnt_q != '0);
                        state_d = IDLE;
                    end else if (sample_edge) begin
                        bit_en_d  = 1'b1;
                        bit_out_d = mosi_s;
                        cnt_d     = cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) begin
                            pend_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                    end else if (sample_edge) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_out_q <= 1'b0;
            bit_en_q  <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            short_q   <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_out_q <= bit_out_d;
            bit_en_q  <= bit_en_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            short_q   <= short_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_en      = bit_en_q;
    assign shift_clr   = clr_q;
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign overrun     = ovr_q;
    assign bit_count   = cnt_q;
    assign frame_count = fcnt_q;

endmodule
